// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter:
//     ST_IDLE / ST_BURST : FSM state encodings
//     arb_state_e        : FSM state type built on those encodings
//     BEAT_W             : beat counter width (holds bursts of up to 15 words)
//     onehot()           : index -> one-hot helper for the grant/ack vectors
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_BURST = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_BURST = ST_BURST
   } arb_state_e;

   // MAX_BURST is limited to 1..15, so four bits always suffice.
   localparam int BEAT_W = 4;

   // One-hot decode of a requester index (up to 8 requesters).
   function automatic logic [7:0] onehot(input int unsigned idx);
      logic [7:0] v;
      v = '0;
      v[idx[2:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundle of the producer-side and FIFO-write-side signals of the arbiter.
//   Handshake: a producer holds req/data/last stable until ack; a word is
//   transferred in the cycle where req_ack[k] is high, which is the same
//   cycle fifo_w_data_stb writes it into the FIFO.
//   Modports:
//     master : environment side (producers + FIFO status), drives requests
//     slave  : arbiter side, drives acks, FIFO write port, grant and busy
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_REQ     = 4,
   parameter int MAX_ENTRIES = 8
);
   localparam int FREE_W = $clog2(MAX_ENTRIES);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ack;
   logic [DATA_WIDTH-1:0]         fifo_w_data;
   logic                          fifo_w_data_stb;
   logic                          fifo_full;
   logic [FREE_W-1:0]             fifo_free_size;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;

   modport master (
      output req, req_data, req_last, fifo_full, fifo_free_size,
      input  req_ack, fifo_w_data, fifo_w_data_stb, grant, busy
   );

   modport slave (
      input  req, req_data, req_last, fifo_full, fifo_free_size,
      output req_ack, fifo_w_data, fifo_w_data_stb, grant, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. Scans requesters starting at
//   rr_ptr+1 and wrapping modulo NUM_REQ; the last owner (rr_ptr itself) is
//   examined last so it only wins again when nobody else is asking.
//   Ports:
//     req    : request vector
//     rr_ptr : index of the previous owner
//     valid  : at least one request is set
//     index  : chosen requester (0 when valid is low)
// ----------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      // Offsets 1..NUM_REQ; the final offset lands back on rr_ptr.
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that lets NUM_REQ producers share the write port of
//   an external FIFO in bursts of up to MAX_BURST words.
//
//   Handshake: producer k holds i_req[k], its data slice and i_req_last[k]
//   until o_req_ack[k]; the acked word is written to the FIFO in that same
//   cycle via o_fifo_w_data/o_fifo_w_data_stb (zero-cycle FIFO latency).
//
//   Ports:
//     i_clk, i_reset       : clock, synchronous active-high reset
//     i_req                : per-producer write request
//     i_req_data           : producer k data at [k*DATA_WIDTH +: DATA_WIDTH]
//     i_req_last           : current word closes the producer's burst
//     o_req_ack            : word of producer k accepted this cycle
//     o_fifo_w_data        : FIFO write data (owner slice, slice 0 when idle)
//     o_fifo_w_data_stb    : FIFO write strobe
//     i_fifo_full          : FIFO full, stalls the current burst
//     i_fifo_free_size     : FIFO free entries, 0 blocks new grants
//     o_grant              : one-hot owner during a burst, zero when idle
//     o_busy               : high while a burst is in progress (FSM state)
//
//   Every burst is preceded by one IDLE arbitration cycle, so bursts from
//   different producers are always separated by one strobe-free cycle.
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_REQ     = 4,
   parameter int MAX_ENTRIES = 8,
   parameter int MAX_BURST   = 4
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [NUM_REQ-1:0]                i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_data,
   input  logic [NUM_REQ-1:0]                i_req_last,
   output logic [NUM_REQ-1:0]                o_req_ack,
   output logic [DATA_WIDTH-1:0]             o_fifo_w_data,
   output logic                              o_fifo_w_data_stb,
   input  logic                              i_fifo_full,
   input  logic [$clog2(MAX_ENTRIES)-1:0]    i_fifo_free_size,
   output logic [NUM_REQ-1:0]                o_grant,
   output logic                              o_busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [BEAT_W-1:0] MAX_BEAT = BEAT_W'(MAX_BURST);

   arb_state_e        state_q,  state_d;
   logic [IDX_W-1:0]  owner_q,  owner_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0] beat_q,   beat_d;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;

   logic              owner_req;
   logic              owner_last;
   logic [DATA_WIDTH-1:0] owner_data;
   logic              stb;
   logic [BEAT_W-1:0] beat_inc;

   // -------------------------------------------------------------------------
   // Rotating-priority pick, only consumed in IDLE.
   // -------------------------------------------------------------------------
   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (i_req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .index  (pick_idx)
   );

   // -------------------------------------------------------------------------
   // Owner view: only the owner's request, last flag and data matter, so
   // non-owner last/data bits never reach the FSM or the FIFO.
   // -------------------------------------------------------------------------
   always_comb begin
      owner_req  = i_req[owner_q];
      owner_last = i_req_last[owner_q];
      owner_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == owner_q) begin
            owner_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A word moves only while bursting, the owner presents one and the FIFO
   // has room.
   assign stb      = (state_q == S_BURST) && owner_req && !i_fifo_full;
   assign beat_inc = beat_q + BEAT_W'(1);

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      o_req_ack         = '0;
      o_grant           = '0;
      o_fifo_w_data_stb = stb;
      o_busy            = (state_q == S_BURST);
      o_fifo_w_data     = i_req_data[DATA_WIDTH-1:0];
      if (state_q == S_BURST) begin
         o_grant[owner_q] = 1'b1;
         o_fifo_w_data    = owner_data;
         if (stb) begin
            o_req_ack[owner_q] = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      beat_d   = beat_q;

      unique case (state_q)
         S_IDLE: begin
            if (pick_valid && (i_fifo_free_size != '0)) begin
               owner_d = pick_idx;
               beat_d  = '0;
               state_d = S_BURST;
            end
         end

         S_BURST: begin
            if (!owner_req) begin
               // Producer withdrew: close the burst without a word.
               state_d  = S_IDLE;
               rr_ptr_d = owner_q;
            end else if (stb) begin
               beat_d = beat_inc;
               if (owner_last || (beat_inc == MAX_BEAT)) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = owner_q;
               end
            end
            // Full FIFO: nothing moves, beat count and owner hold.
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers. Reset leaves producer 0 with top priority by parking
   // the pointer on the highest index.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         beat_q   <= beat_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (DATA_WIDTH=16, NUM_REQ=4,
//   MAX_ENTRIES=8, MAX_BURST=4). Producers are modelled by word counters;
//   every expected FIFO write {ack, data} is queued when a scenario is
//   loaded and popped whenever the DUT strobes.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int DW = 16;
   localparam int NR = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_ENTRIES(8)) bus();

   fifo_wr_arbiter #(
      .DATA_WIDTH  (DW),
      .NUM_REQ     (NR),
      .MAX_ENTRIES (8),
      .MAX_BURST   (4)
   ) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .i_req             (bus.req),
      .i_req_data        (bus.req_data),
      .i_req_last        (bus.req_last),
      .o_req_ack         (bus.req_ack),
      .o_fifo_w_data     (bus.fifo_w_data),
      .o_fifo_w_data_stb (bus.fifo_w_data_stb),
      .i_fifo_full       (bus.fifo_full),
      .i_fifo_free_size  (bus.fifo_free_size),
      .o_grant           (bus.grant),
      .o_busy            (bus.busy)
   );

   // ---------------- scoreboard / producer model ----------------
   logic [19:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   logic [15:0] base    [NR];
   int          left    [NR];
   int          seq     [NR];
   bit          last_en [NR];
   bit          last_ev [NR];

   logic [3:0]  s_grant, s_ack;
   logic        s_stb, s_busy;
   logic [15:0] s_data;
   logic [31:0] stb_pat, busy_pat;
   logic [3:0]  ghist [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int k, input int n, input bit le, input bit ev);
      base[k]    = {4'(k), 12'($urandom_range(0, 4000))};
      left[k]    = n;
      seq[k]     = 0;
      last_en[k] = le;
      last_ev[k] = ev;
   endtask

   task automatic push(input int k, input int s);
      logic [3:0] oh;
      oh = 4'(1 << k);
      exp_q.push_back({oh, base[k] + 16'(s)});
   endtask

   // Present each producer's current word; idle producers show junk.
   task automatic drive();
      for (int k = 0; k < NR; k++) begin
         if (left[k] > 0) begin
            bus.req[k]              = 1'b1;
            bus.req_data[k*DW +: DW] = base[k] + 16'(seq[k]);
            bus.req_last[k]         = last_ev[k] || (last_en[k] && left[k] == 1);
         end else begin
            bus.req[k]              = 1'b0;
            bus.req_data[k*DW +: DW] = 16'($urandom);
            bus.req_last[k]         = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Sample at the falling edge, then advance the producers past the
   // rising edge that accepted their words.
   task automatic tick();
      logic [19:0] e;
      @(negedge clk);
      s_grant = bus.grant;
      s_stb   = bus.fifo_w_data_stb;
      s_busy  = bus.busy;
      s_ack   = bus.req_ack;
      s_data  = bus.fifo_w_data;
      if (s_stb) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_word", {12'd0, s_ack, s_data}, {12'd0, e});
         end
      end else begin
         chk("ack_without_stb", {28'd0, s_ack}, 32'd0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
         if (s_ack[k] === 1'b1 && left[k] > 0) begin
            left[k]--;
            seq[k]++;
         end
      end
   endtask

   // Run n cycles; full/reset patterns are MSB = first cycle.
   task automatic run(input int n, input logic [31:0] full_pat, input logic [31:0] rst_pat);
      stb_pat  = '0;
      busy_pat = '0;
      for (int i = 0; i < n; i++) begin
         bus.fifo_full = full_pat[n-1-i];
         rst           = rst_pat[n-1-i];
         drive();
         tick();
         stb_pat  = {stb_pat[30:0], s_stb};
         busy_pat = {busy_pat[30:0], s_busy};
         ghist[i] = s_grant;
      end
      bus.fifo_full = 1'b0;
      rst           = 1'b0;
      drive();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int k = 0; k < NR; k++) load(k, 0, 1'b0, 1'b0);
      rst                = 1'b1;
      bus.fifo_full      = 1'b0;
      bus.fifo_free_size = 3'd7;
      drive();

      // Reset state
      run(2, 32'd0, 32'b11);
      chk("rst_grant", {28'd0, s_grant}, 32'd0);
      chk("rst_stb",   {31'd0, s_stb},   32'd0);
      chk("rst_busy",  {31'd0, s_busy},  32'd0);
      chk("rst_ack",   {28'd0, s_ack},   32'd0);

      // Single producer, 3 words, last on the 3rd
      load(0, 3, 1'b1, 1'b0);
      for (int s = 0; s < 3; s++) push(0, s);
      run(5, 32'd0, 32'd0);
      chk("single_stb",    stb_pat,  32'b01110);
      chk("single_busy",   busy_pat, 32'b01110);
      chk("single_grant1", {28'd0, ghist[1]}, 32'b0001);
      chk("single_grant3", {28'd0, ghist[3]}, 32'b0001);
      chk("single_grant4", {28'd0, ghist[4]}, 32'd0);

      // Burst cap: producer 2, 10 words, no last
      load(2, 10, 1'b0, 1'b0);
      for (int s = 0; s < 10; s++) push(2, s);
      run(15, 32'd0, 32'd0);
      chk("cap_stb",    stb_pat,  32'b011110111101100);
      chk("cap_busy",   busy_pat, 32'b011110111101110);
      chk("cap_grant1", {28'd0, ghist[1]},  32'b0100);
      chk("cap_gap",    {28'd0, ghist[5]},  32'd0);
      chk("cap_regrant",{28'd0, ghist[6]},  32'b0100);
      chk("cap_drop",   {28'd0, ghist[13]}, 32'b0100);

      // Round robin from reset: all four request, 1-word bursts
      run(1, 32'd0, 32'b1);
      load(0, 2, 1'b0, 1'b1);
      for (int k = 1; k < NR; k++) load(k, 1, 1'b0, 1'b1);
      push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(0, 1);
      run(11, 32'd0, 32'd0);
      chk("rr_stb",  stb_pat,  32'b01010101010);
      chk("rr_busy", busy_pat, 32'b01010101010);
      chk("rr_g0",   {28'd0, ghist[1]}, 32'b0001);
      chk("rr_g1",   {28'd0, ghist[3]}, 32'b0010);
      chk("rr_g2",   {28'd0, ghist[5]}, 32'b0100);
      chk("rr_g3",   {28'd0, ghist[7]}, 32'b1000);
      chk("rr_g4",   {28'd0, ghist[9]}, 32'b0001);

      // Full stall: owner 1, FIFO full for 3 cycles after two words
      load(1, 4, 1'b0, 1'b0);
      for (int s = 0; s < 4; s++) push(1, s);
      run(9, 32'b000111000, 32'd0);
      chk("stall_stb",   stb_pat,  32'b011000110);
      chk("stall_busy",  busy_pat, 32'b011111110);
      chk("stall_grant", {28'd0, ghist[4]}, 32'b0010);
      chk("stall_end",   {28'd0, ghist[8]}, 32'd0);

      // Free size 0 blocks arbitration, 1 allows it
      bus.fifo_free_size = 3'd0;
      load(2, 1, 1'b1, 1'b0);
      push(2, 0);
      run(3, 32'd0, 32'd0);
      chk("free0_stb",   stb_pat,  32'd0);
      chk("free0_busy",  busy_pat, 32'd0);
      chk("free0_grant", {28'd0, ghist[2]}, 32'd0);
      bus.fifo_free_size = 3'd1;
      run(3, 32'd0, 32'd0);
      chk("free1_stb",   stb_pat, 32'b010);
      chk("free1_grant", {28'd0, ghist[1]}, 32'b0100);
      bus.fifo_free_size = 3'd7;

      // Reset in the middle of a producer 3 burst
      load(3, 4, 1'b0, 1'b0);
      push(3, 0); push(3, 1);
      run(4, 32'b0001, 32'b0001);
      chk("rstb_stb",  stb_pat,  32'b0110);
      chk("rstb_busy", busy_pat, 32'b0111);
      load(0, 1, 1'b1, 1'b0);
      push(0, 0); push(3, 2); push(3, 3);
      run(7, 32'd0, 32'd0);
      chk("rstb_post_grant", {28'd0, ghist[0]}, 32'd0);
      chk("rstb_post_stb",   stb_pat,  32'b0101100);
      chk("rstb_post_busy",  busy_pat, 32'b0101110);
      chk("rstb_first",      {28'd0, ghist[1]}, 32'b0001);
      chk("rstb_second",     {28'd0, ghist[3]}, 32'b1000);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
